// File: rtl/wb_stage_pipelined.sv
// rtl/wb_stage_pipelined.sv - MEM/WB pipeline register with result select, forwarding tap and retire counter
// Optional load narrowing/extension is compiled in with `define WB_LOAD_EXT_EN.
module wb_stage_pipelined #(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] link_pc,
    input  logic [1:0]        wb_sel,
    input  logic              reg_write,
    input  logic [REG_AW-1:0] rd,
    input  logic [1:0]        load_size,
    input  logic              load_signed,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired
);

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] sel_data;
    logic              cap;
    logic              stage_valid;
    logic              wr_q;

`ifdef WB_LOAD_EXT_EN
    // Narrowing via shift-left then (arithmetic) shift-right keeps this width-agnostic;
    // sizes at or above DATA_W get a zero shift and pass through unchanged.
    localparam int SH_B = (DATA_W > 8)  ? DATA_W - 8  : 0;
    localparam int SH_H = (DATA_W > 16) ? DATA_W - 16 : 0;
    localparam int SH_W = (DATA_W > 32) ? DATA_W - 32 : 0;
    localparam int SH_D = (DATA_W > 64) ? DATA_W - 64 : 0;

    int                sh;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        sh = SH_D;
        case (load_size)
            2'd0:    sh = SH_B;
            2'd1:    sh = SH_H;
            2'd2:    sh = SH_W;
            default: sh = SH_D;
        endcase
        shifted = read_data << sh;
        if (load_signed)
            load_data = DATA_W'($signed(shifted) >>> sh);
        else
            load_data = shifted >> sh;
    end
`else
    wire unused_load_cfg = ^{load_size, load_signed};

    always_comb begin
        load_data = read_data;
    end
`endif

    always_comb begin
        case (wb_sel)
            2'd1:    sel_data = load_data;
            2'd2:    sel_data = link_pc;
            default: sel_data = alu_result;
        endcase
    end

    assign cap      = in_valid && !stall;
    assign in_ready = !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid <= 1'b0;
            wr_q        <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            retired     <= '0;
        end else if (!stall) begin
            if (cap && !flush) begin
                stage_valid <= 1'b1;
                wr_q        <= reg_write && (rd != REG_AW'(ZERO_REG));
                rf_waddr    <= rd;
                rf_wdata    <= sel_data;
                retired     <= retired + 1'b1;
            end else begin
                // Bubble: address/data keep their last values, only the write is killed.
                stage_valid <= 1'b0;
                wr_q        <= 1'b0;
            end
        end
    end

    assign rf_we     = stage_valid && wr_q;
    assign fwd_valid = rf_we;
    assign fwd_addr  = rf_waddr;
    assign fwd_data  = rf_wdata;

endmodule

// File: doc/wb_stage_pipelined.md
Name: wb_stage_pipelined

Overview:
Parametrised successor to the combinational write-back stage. It adds the MEM/WB pipeline register, a valid/stall handshake, three-way result selection (ALU, memory, link PC), zero-register write suppression, a forwarding tap and a retired-instruction counter. It sits between the memory stage and the register-file write port, and drives the forwarding unit.

Parameters:
DATA_W, 64, datapath width in bits
REG_AW, 5, register address width
ZERO_REG, 31, register index that is never written (XZR)
CNT_W, 32, retired-instruction counter width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold the stage register; no capture this cycle
flush  input  1  capture a bubble instead of the incoming instruction
in_valid  input  1  MEM stage presents a valid instruction
in_ready  output  1  stage will capture this cycle; equals !stall
alu_result  input  DATA_W  ALU result
read_data  input  DATA_W  data-memory read data
link_pc  input  DATA_W  PC+4 for BL
wb_sel  input  2  0=ALU, 1=memory, 2=link PC, 3=reserved (treated as ALU)
reg_write  input  1  instruction writes a register
rd  input  REG_AW  destination register
load_size  input  2  0=byte, 1=half, 2=word, 3=double (used only with the optional feature)
load_signed  input  1  sign-extend the load (used only with the optional feature)
rf_we  output  1  register-file write enable
rf_waddr  output  REG_AW  register-file write address
rf_wdata  output  DATA_W  register-file write data
fwd_valid  output  1  a forwardable result is in the stage; equals rf_we
fwd_addr  output  REG_AW  equals rf_waddr
fwd_data  output  DATA_W  equals rf_wdata
retired  output  CNT_W  count of valid instructions retired

Behaviour:
- Reset (asynchronous, takes effect immediately): rf_we=0, rf_waddr=0, rf_wdata=0, retired=0, internal valid=0.
- Select (combinational, before the register):
  - wb_sel=1: read_data, after extension when the optional feature is compiled in.
  - wb_sel=2: link_pc.
  - Otherwise: alu_result.
- Capture condition is cap = in_valid && !stall.
  - cap && !flush: register the selected data and rd; internal valid<=1; rf_we<=reg_write && (rd != ZERO_REG).
  - !stall && (flush || !in_valid): bubble. valid<=0, rf_we<=0. rf_waddr and rf_wdata hold their values.
  - stall=1: all registers hold, including rf_we. The same write is re-presented each cycle and is idempotent at the register file. flush is ignored while stall=1.
- Latency: inputs appear on rf_* exactly 1 cycle after capture.
- Forwarding tap: fwd_* are wired directly to rf_*, with no added delay.
- retired increments on each rising edge where a non-flushed instruction is captured (cap && !flush).
  - An instruction with reg_write=0 (for example STUR or B) still counts.
  - retired wraps modulo 2^CNT_W; it does not saturate.
- A write to ZERO_REG counts as retired but never asserts rf_we.
- Reset asserted mid-stall: clears everything; the held instruction is dropped and not counted.

Optional Feature:
Macro WB_LOAD_EXT_EN.
- Defined: when wb_sel=1, read_data is narrowed per load_size to the low 8, 16, 32 or 64 bits. The result is sign-extended to DATA_W when load_signed=1 and zero-extended otherwise. For DATA_W<64, the double size (3) passes read_data through unchanged.
- Undefined: read_data passes through unchanged, and load_size and load_signed are ignored.

Test Plan:
- Reset, then one ALU op with rd=3, alu_result=0x1234, reg_write=1 -> next cycle: rf_we=1, rf_waddr=3, rf_wdata=0x1234, fwd_valid=1, retired=1.
- BL with wb_sel=2, link_pc=0x100, rd=30 -> rf_wdata=0x100, rf_waddr=30. Then LDUR with wb_sel=1, read_data=0xDEAD, rd=5 -> rf_wdata=0xDEAD.
- Write to rd=31 with reg_write=1 -> rf_we=0, retired still increments by 1.
- stall=1 for 3 cycles after a capture, with new inputs applied -> rf_* unchanged and retired unchanged. Release the stall -> the new instruction appears 1 cycle later.
- flush=1 with in_valid=1 -> rf_we=0 next cycle, retired unchanged. Assert reset asynchronously mid-stall -> rf_we=0 and retired=0 before the next edge.
- With WB_LOAD_EXT_EN defined: read_data=0x80, load_size=0, load_signed=1 -> rf_wdata=0xFFFF_FFFF_FFFF_FF80. Same with load_signed=0 -> 0x80. With the macro undefined: read_data=0x80 -> 0x80 for any load_size.
